systolic_drain: RTL and testbench

Result drain stage that sits directly downstream of the 2x2 systolic array. On a `start` pulse it waits a fixed number of cycles for the array's accumulators to settle, then snapshots all four 16-bit results into a holding buffer. It streams them out one per beat in row-major order over a valid/ready handshake. Row-major order is C00, C01, C10, C11. The array is then free to start the next computation while the drain is still emptying.

---
 rtl/systolic_drain_if.sv | 10 +
 rtl/systolic_drain.sv | 91 +++++++++
 tb/tb_systolic_drain.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_drain_if.sv
// systolic_drain_if: valid/ready result stream from the drain stage to its consumer
interface systolic_drain_if #(parameter int DATA_W = 16);
    logic [DATA_W-1:0] out_data;
    logic [1:0] out_idx;
    logic out_valid;
    logic out_ready;
    logic out_last;
    modport master(output out_data, out_idx, out_valid, out_last, input out_ready);
    modport slave(input out_data, out_idx, out_valid, out_last, output out_ready);
endinterface

// File: rtl/systolic_drain.sv
// systolic_drain: settle, snapshot and stream the 2x2 array results in row-major order.
// Define SYSTOLIC_DRAIN_RELU_EN to store negative results as 0 at capture.
module systolic_drain #(
    parameter int DATA_W = 16,
    parameter int SETTLE_CYCLES = 6
) (
    input logic clk,
    input logic rst,
    input logic start,
    input logic [DATA_W-1:0] c00,
    input logic [DATA_W-1:0] c01,
    input logic [DATA_W-1:0] c10,
    input logic [DATA_W-1:0] c11,
    systolic_drain_if.master o,
    output logic busy,
    output logic overrun
);
    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;
    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] buf_q [4];
    logic [DATA_W-1:0] buf_d [4];
    logic overrun_q, overrun_d;
    logic valid, xfer, last_xfer;

    function automatic logic [DATA_W-1:0] cap(input logic [DATA_W-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        buf_d = buf_q;
        overrun_d = overrun_q;
        valid = state_q == STREAM;
        xfer = valid && o.out_ready;
        last_xfer = xfer && ptr_q == 2'd3;
        if (state_q == IDLE) begin
            if (start) begin
                cnt_d = '0;
                state_d = WAIT;
            end
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 4'd1;
            overrun_d = overrun_q | start;
            if (cnt_q == LAST_CNT) begin
                buf_d = '{cap(c00), cap(c01), cap(c10), cap(c11)};
                ptr_d = '0;
                state_d = STREAM;
            end
        end else begin
            // a start coinciding with the final transfer chains straight into the next run
            overrun_d = overrun_q | (start && !last_xfer);
            if (xfer) ptr_d = ptr_q + 2'd1;
            if (last_xfer) begin
                cnt_d = '0;
                state_d = start ? WAIT : IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            ptr_q <= '0;
            buf_q <= '{default: '0};
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            buf_q <= buf_d;
            overrun_q <= overrun_d;
        end
    end

    assign o.out_valid = valid;
    assign o.out_data = valid ? buf_q[ptr_q] : '0;
    assign o.out_idx = valid ? ptr_q : 2'd0;
    assign o.out_last = valid && ptr_q == 2'd3;
    assign busy = state_q != IDLE;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: randomized scenarios against a queue-based model of the drain stage
module tb_systolic_drain;
    localparam int W = 16;
    localparam int SC = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] cv [4];
    logic busy, overrun;
    int checks = 0;
    int failures = 0;
    bit exp_ovr = 1'b0;
    int drop_beat = -1;
    bit b2b = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] nxt_vals [4];
    bit rdy_pat[$];

    systolic_drain_if #(.DATA_W(W)) o();

    systolic_drain #(.DATA_W(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .c00(cv[0]), .c01(cv[1]), .c10(cv[2]), .c11(cv[3]),
        .o(o), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_capture(input logic [W-1:0] v [4], input int drop_k);
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(model(v[i]));
        for (int k = 1; k <= SC; k++) begin
            checks++;
            if (o.out_valid !== 1'b0 || busy !== 1'b1 || overrun !== exp_ovr) begin
                failures++;
                $display("FAIL wait k=%0d valid=%b busy=%b overrun=%b expected valid=0 busy=1 overrun=%b",
                         k, o.out_valid, busy, overrun, exp_ovr);
            end
            start = (k == drop_k);
            if (start) exp_ovr = 1'b1;
            for (int i = 0; i < 4; i++) cv[i] = (k == SC) ? v[i] : W'($urandom);
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) cv[i] = W'($urandom);
        checks++;
        if (o.out_valid !== 1'b1 || o.out_idx !== 2'd0) begin
            failures++;
            $display("FAIL capture_latency valid=%b idx=%0d expected valid=1 idx=0", o.out_valid, o.out_idx);
        end
    endtask

    task automatic launch(input logic [W-1:0] v [4], input int drop_k);
        start = 1'b1;
        for (int i = 0; i < 4; i++) cv[i] = W'($urandom);
        step();
        start = 1'b0;
        wait_capture(v, drop_k);
    endtask

    task automatic drain_check(input string name, input int nbeats, input int budget);
        int n = 0;
        int cyc = 0;
        bit dropped = 1'b0;
        while (n < nbeats && cyc < budget) begin
            o.out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
            start = 1'b0;
            checks++;
            if (o.out_valid !== 1'b1 || o.out_data !== exp_q[n] || o.out_idx !== 2'(n) ||
                o.out_last !== (n == 3) || overrun !== exp_ovr) begin
                failures++;
                $display("FAIL %s beat%0d valid=%b data=%h idx=%0d last=%b ovr=%b expected valid=1 data=%h idx=%0d last=%b ovr=%b",
                         name, n, o.out_valid, o.out_data, o.out_idx, o.out_last, overrun,
                         exp_q[n], n, n == 3, exp_ovr);
            end
            if (n == drop_beat && !o.out_ready && !dropped) begin
                start = 1'b1;
                dropped = 1'b1;
                exp_ovr = 1'b1;
            end
            if (b2b && n == 3 && o.out_ready) begin
                start = 1'b1;
                for (int i = 0; i < 4; i++) cv[i] = nxt_vals[i];
            end
            if (o.out_ready) n++;
            step();
            cyc++;
        end
        start = 1'b0;
        o.out_ready = 1'b1;
        rdy_pat = {};
        checks++;
        if (n != nbeats) begin
            failures++;
            $display("FAIL %s_timeout beats=%0d expected %0d", name, n, nbeats);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        o.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cv[i] = W'($urandom);
        step();
        step();
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if (o.out_valid !== 1'b0 || o.out_data !== '0 || o.out_idx !== 2'd0 || o.out_last !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset valid=%b data=%h idx=%0d last=%b busy=%b ovr=%b expected all 0",
                     o.out_valid, o.out_data, o.out_idx, o.out_last, busy, overrun);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] v [4];
        v = '{16'd19, 16'd22, 16'd43, 16'd50};
        launch(v, 0);
        drain_check("basic", 4, 40);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy !== 1'b0 || o.out_valid !== 1'b0 || o.out_data !== '0 || o.out_last !== 1'b0) begin
                failures++;
                $display("FAIL basic_idle%0d busy=%b valid=%b data=%h last=%b expected 0 0 0 0",
                         k, busy, o.out_valid, o.out_data, o.out_last);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v [4];
        v = '{16'd19, 16'd22, 16'd43, 16'd50};
        launch(v, 0);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        drain_check("backpressure", 4, 7);
        checks++;
        if (busy !== 1'b0 || o.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_idle busy=%b valid=%b expected 0 0", busy, o.out_valid);
        end
    endtask

    task automatic test_negative();
        logic [W-1:0] v [4];
        v = '{16'd5, 16'hFFF9, 16'h7FFF, 16'h8000};
        launch(v, 0);
        rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b1};
        drain_check("negative", 4, 40);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v [4];
        v = '{16'd19, 16'd22, 16'd43, 16'd50};
        nxt_vals = '{16'd1, 16'd2, 16'd3, 16'd4};
        launch(v, 0);
        b2b = 1'b1;
        drain_check("b2b_first", 4, 40);
        b2b = 1'b0;
        wait_capture(nxt_vals, 0);
        drain_check("b2b_second", 4, 40);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end busy=%b ovr=%b expected 0 0", busy, overrun);
        end
    endtask

    task automatic test_dropped_start();
        logic [W-1:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = W'($urandom);
        launch(v, 3);
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        drop_beat = 1;
        drain_check("dropped", 4, 40);
        drop_beat = -1;
        checks++;
        if (busy !== 1'b0 || o.out_valid !== 1'b0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL dropped_end busy=%b valid=%b ovr=%b expected 0 0 1", busy, o.out_valid, overrun);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [W-1:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = W'($urandom);
        launch(v, 0);
        drain_check("mid_partial", 2, 20);
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        exp_ovr = 1'b0;
        checks++;
        if (o.out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset valid=%b busy=%b ovr=%b expected 0 0 0", o.out_valid, busy, overrun);
        end
        step();
        checks++;
        if (o.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_resume valid=%b busy=%b expected 0 0", o.out_valid, busy);
        end
        for (int i = 0; i < 4; i++) v[i] = W'($urandom);
        launch(v, 0);
        drain_check("mid_fresh", 4, 40);
    endtask

    task automatic test_random();
        logic [W-1:0] v [4];
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) v[i] = W'($urandom);
            launch(v, 0);
            for (int j = $urandom_range(0, 10); j > 0; j--) rdy_pat.push_back(1'($urandom_range(0, 1)));
            drain_check("random", 4, 40);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
            checks++;
            if (busy !== 1'b0 || o.out_valid !== 1'b0 || overrun !== 1'b0) begin
                failures++;
                $display("FAIL random_idle%0d busy=%b valid=%b ovr=%b expected 0 0 0", r, busy, o.out_valid, overrun);
            end
        end
    endtask

    initial begin
        o.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cv[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_negative();
        test_back_to_back();
        test_dropped_start();
        test_reset_mid_stream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
